rf_write_ctrl: RTL and testbench

Write-side controller and read-port front end for the eight-entry 16-bit register bank. It merges two writeback sources into the bank's single write port: ALU results, which always win, and load returns, which are buffered in a 2-entry FIFO with ready/valid backpressure. It drives the bank's one-hot `write[7:0]` and `writedata[15:0]` from registers. It also provides two read ports that select among the bank outputs `read0..read7`, with write-through forwarding and a pending-load hazard flag.

---
 rtl/rf_write_ctrl_if.sv | 37 +++
 rtl/rf_write_ctrl.sv | 107 ++++++++++
 tb/tb_rf_write_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rf_write_ctrl_if.sv
// Bus bundle for the register-bank write controller: ALU and load writeback
// requests, the bank write port, the bank outputs and the two read ports.
interface rf_write_ctrl_if;
    logic        alu_valid;
    logic [2:0]  alu_reg;
    logic [15:0] alu_data;
    logic        ld_valid;
    logic [2:0]  ld_reg;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic [7:0]  write;
    logic [15:0] writedata;
    logic [15:0] read0, read1, read2, read3, read4, read5, read6, read7;
    logic [2:0]  rd_sel0, rd_sel1;
    logic [15:0] rd_data0, rd_data1;
    logic        rd_busy0, rd_busy1;

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  ld_valid, ld_reg, ld_data,
        output ld_ready,
        output write, writedata,
        input  read0, read1, read2, read3, read4, read5, read6, read7,
        input  rd_sel0, rd_sel1,
        output rd_data0, rd_data1, rd_busy0, rd_busy1
    );

    modport master (
        output alu_valid, alu_reg, alu_data,
        output ld_valid, ld_reg, ld_data,
        input  ld_ready,
        input  write, writedata,
        output read0, read1, read2, read3, read4, read5, read6, read7,
        output rd_sel0, rd_sel1,
        input  rd_data0, rd_data1, rd_busy0, rd_busy1
    );
endinterface

// File: rtl/rf_write_ctrl.sv
// Write-port arbiter for the 8x16 register bank. ALU writebacks always win;
// load returns wait in a 2-entry FIFO and are squashed when a younger ALU
// write targets the same register. Also provides two forwarding read ports.
module rf_write_ctrl (
    input  logic           clk,
    input  logic           rst,
    rf_write_ctrl_if.slave bus
);
    logic [1:0]  live;
    logic [2:0]  ent_reg  [2];
    logic [15:0] ent_data [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;
    logic [7:0]  write_q;
    logic [15:0] writedata_q;

    logic        push;
    logic        pop;
    logic        issue;
    logic [2:0]  issue_reg;
    logic [15:0] issue_data;
    logic [15:0] bank [8];

    // ready does not anticipate a same-cycle pop, so a full FIFO stays full
    // for one cycle after the ALU goes idle
    assign bus.ld_ready = !rst && (count < 2'd2);
    assign push         = bus.ld_valid && bus.ld_ready;
    assign pop          = !bus.alu_valid && (count != 2'd0);

    assign bus.write     = write_q;
    assign bus.writedata = writedata_q;

    assign bank = '{bus.read0, bus.read1, bus.read2, bus.read3,
                    bus.read4, bus.read5, bus.read6, bus.read7};

    // pick this cycle's write: ALU first, else the FIFO head if still live
    always_comb begin
        issue      = 1'b0;
        issue_reg  = 3'd0;
        issue_data = 16'd0;
        if (bus.alu_valid) begin
            issue      = 1'b1;
            issue_reg  = bus.alu_reg;
            issue_data = bus.alu_data;
        end else if (pop && live[head]) begin
            issue      = 1'b1;
            issue_reg  = ent_reg[head];
            issue_data = ent_data[head];
        end
    end

    // FIFO bookkeeping and the registered bank write port
    always_ff @(posedge clk) begin
        if (rst) begin
            live        <= 2'b00;
            head        <= 1'b0;
            tail        <= 1'b0;
            count       <= 2'd0;
            write_q     <= 8'd0;
            writedata_q <= 16'd0;
        end else begin
            if (issue) begin
                write_q     <= 8'd1 << issue_reg;
                writedata_q <= issue_data;
            end else begin
                write_q     <= 8'd0;
            end

            // a younger ALU write makes queued loads to the same register stale
            for (int i = 0; i < 2; i++) begin
                if (bus.alu_valid && ent_reg[i] == bus.alu_reg) begin
                    live[i] <= 1'b0;
                end
            end

            // live is cleared on pop so that live alone implies occupancy
            if (pop) begin
                live[head] <= 1'b0;
                head       <= ~head;
            end

            if (push) begin
                live[tail]     <= !(bus.alu_valid && bus.ld_reg == bus.alu_reg);
                ent_reg[tail]  <= bus.ld_reg;
                ent_data[tail] <= bus.ld_data;
                tail           <= ~tail;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // read ports: forward the in-flight write, flag registers with a pending load
    always_comb begin
        bus.rd_data0 = write_q[bus.rd_sel0] ? writedata_q : bank[bus.rd_sel0];
        bus.rd_data1 = write_q[bus.rd_sel1] ? writedata_q : bank[bus.rd_sel1];
        bus.rd_busy0 = (live[0] && ent_reg[0] == bus.rd_sel0) ||
                       (live[1] && ent_reg[1] == bus.rd_sel0);
        bus.rd_busy1 = (live[0] && ent_reg[0] == bus.rd_sel1) ||
                       (live[1] && ent_reg[1] == bus.rd_sel1);
    end
endmodule

// File: tb/tb_rf_write_ctrl.sv
// Bench for rf_write_ctrl: directed scenarios followed by random traffic,
// all checked against a queue-based model of the write-port arbitration.
module tb_rf_write_ctrl;
    logic clk = 1'b0;
    logic rst;

    rf_write_ctrl_if bus ();

    rf_write_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        live;
        bit [2:0]  r;
        bit [15:0] d;
    } ent_t;

    ent_t      q [$];
    bit [7:0]  m_write;
    bit [15:0] m_wd;
    bit [15:0] rv [8];
    int        n_total = 0;
    int        n_bad   = 0;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit busy_for(input bit [2:0] s);
        foreach (q[i]) begin
            if (q[i].live && q[i].r == s) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model across the rising edge.
    task automatic step(input bit av, input bit [2:0] ar, input bit [15:0] ad,
                        input bit lv, input bit [2:0] lr, input bit [15:0] ld,
                        input bit r, input bit [2:0] s0);
        bit       push;
        bit [2:0] s1;
        ent_t     e;
        s1 = 3'($urandom_range(0, 7));
        @(negedge clk);
        rst           = r;
        bus.alu_valid = av;
        bus.alu_reg   = ar;
        bus.alu_data  = ad;
        bus.ld_valid  = lv;
        bus.ld_reg    = lr;
        bus.ld_data   = ld;
        bus.rd_sel0   = s0;
        bus.rd_sel1   = s1;
        for (int i = 0; i < 8; i++) rv[i] = 16'($urandom);
        bus.read0 = rv[0]; bus.read1 = rv[1]; bus.read2 = rv[2]; bus.read3 = rv[3];
        bus.read4 = rv[4]; bus.read5 = rv[5]; bus.read6 = rv[6]; bus.read7 = rv[7];
        #1;
        check_val("ld_ready",  16'(bus.ld_ready), 16'(!r && q.size() < 2));
        check_val("write",     16'(bus.write), 16'(m_write));
        check_val("writedata", bus.writedata, m_wd);
        check_val("rd_data0",  bus.rd_data0, m_write[s0] ? m_wd : rv[s0]);
        check_val("rd_data1",  bus.rd_data1, m_write[s1] ? m_wd : rv[s1]);
        check_val("rd_busy0",  16'(bus.rd_busy0), 16'(busy_for(s0)));
        check_val("rd_busy1",  16'(bus.rd_busy1), 16'(busy_for(s1)));
        @(posedge clk);
        if (r) begin
            q.delete();
            m_write = 8'd0;
            m_wd    = 16'd0;
        end else begin
            push = lv && (q.size() < 2);
            if (av) begin
                foreach (q[i]) if (q[i].r == ar) q[i].live = 1'b0;
                m_write = 8'd1 << ar;
                m_wd    = ad;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                if (e.live) begin
                    m_write = 8'd1 << e.r;
                    m_wd    = e.d;
                end else begin
                    m_write = 8'd0;
                end
            end else begin
                m_write = 8'd0;
            end
            if (push) q.push_back('{live: !(av && lr == ar), r: lr, d: ld});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 3'($urandom_range(0, 7)));
    endtask

    initial begin
        rst = 1'b1;
        bus.alu_valid = 0; bus.alu_reg = 0; bus.alu_data = 0;
        bus.ld_valid  = 0; bus.ld_reg  = 0; bus.ld_data  = 0;
        bus.rd_sel0   = 0; bus.rd_sel1 = 0;
        bus.read0 = 0; bus.read1 = 0; bus.read2 = 0; bus.read3 = 0;
        bus.read4 = 0; bus.read5 = 0; bus.read6 = 0; bus.read7 = 0;
        m_write = 0; m_wd = 0;
        @(posedge clk);
        step(0, 0, 0, 1, 2, 16'h1111, 1, 2);
        idle(1);

        // ALU write r3 = 0x1234
        step(1, 3, 16'h1234, 0, 0, 0, 0, 3);
        #1;
        check_val("alu_write_strobe", 16'(bus.write), 16'h0008);
        check_val("alu_forward", bus.rd_data0, 16'h1234);
        step(0, 0, 0, 0, 0, 0, 0, 3);
        #1;
        check_val("alu_strobe_end", 16'(bus.write), 16'h0000);
        idle(1);

        // load backpressure under a busy ALU
        step(1, 6, 16'h0601, 1, 1, 16'hAAAA, 0, 1);
        step(1, 6, 16'h0602, 1, 2, 16'hBBBB, 0, 2);
        #1;
        check_val("bp_full", 16'(bus.ld_ready), 16'h0000);
        step(1, 6, 16'h0603, 1, 3, 16'hCCCC, 0, 1);
        step(1, 6, 16'h0604, 1, 3, 16'hCCCC, 0, 2);
        step(1, 6, 16'h0605, 1, 3, 16'hCCCC, 0, 3);
        step(0, 0, 0, 1, 3, 16'hCCCC, 0, 1);
        #1;
        check_val("bp_r1", 16'(bus.write), 16'h0002);
        step(0, 0, 0, 0, 0, 0, 0, 2);
        #1;
        check_val("bp_r2_data", bus.writedata, 16'hBBBB);
        idle(3);

        // squash a queued load with a younger ALU write
        step(0, 0, 0, 1, 5, 16'h5555, 0, 5);
        step(1, 5, 16'h7777, 0, 0, 0, 0, 5);
        #1;
        check_val("squash_busy", 16'(bus.rd_busy0), 16'h0000);
        idle(3);

        // same-cycle push and squash
        step(1, 4, 16'h4444, 1, 4, 16'h9999, 0, 4);
        idle(3);

        // reset while two loads are queued
        step(1, 0, 16'h0101, 1, 6, 16'h6666, 0, 6);
        step(1, 1, 16'h0202, 1, 7, 16'h7070, 0, 7);
        step(0, 0, 0, 0, 0, 0, 1, 6);
        idle(3);
        #1;
        check_val("reset_drop", 16'(bus.write), 16'h0000);

        // back-to-back loads with the ALU idle
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 3'(i), 16'(16'hA000 + i), 0, 3'(i));
        idle(3);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, 99) == 0, 3'($urandom_range(0, 7)));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
